boa_div_ctl: RTL and testbench
==============================

Name: boa_div_ctl

Overview:
Iterative integer divider with its sequencer, serving RV32M DIV/DIVU/REM/REMU for the EX stage. EX stalls while the block is busy. The block accepts one request, runs a restoring shift-subtract loop over several cycles, applies sign fix-up, and holds the result until EX consumes it. It replaces the fixed-latency pipelined divider and delay counter, so the stall length now depends on the operands.

Parameters:
bits_per_cycle, 1, quotient bits resolved per CALC cycle. Legal values are 1, 2 and 4. Iteration count N = 32/bits_per_cycle.

Ports:
clk  in  1  CPU clock.
rst  in  1  synchronous active-high reset.
clear  in  1  pipeline flush: abort the current operation and drop any held result.
d_valid  in  1  request valid.
d_ready  out  1  block can accept a request; high only in IDLE.
d_funct3  in  3  RV funct3 of the request: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
d_lhs  in  32  dividend (rs1).
d_rhs  in  32  divisor (rs2).
q_valid  out  1  result valid.
q_ready  in  1  EX consumes the result.
q_res  out  32  quotient or remainder, selected by funct3[1].
busy  out  1  state != IDLE; feeds the EX stall request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, q_valid=0, d_ready=1, busy=0, q_res=0, cache invalid.
- State machine: IDLE, CALC, FIXUP, DONE.
- Accept: d_valid && d_ready && !clear at a clock edge. On accept, latch funct3, sign flags and operand magnitudes.
  - Signed ops take the two's-complement absolute value. Unsigned ops pass operands through.
- Special cases bypass CALC and go IDLE->DONE in one edge:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = d_lhs, for both signed and unsigned.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC:
  - Each edge shifts bits_per_cycle dividend bits into a 33-bit partial remainder and performs bits_per_cycle trial subtracts.
  - The iteration counter counts down from N-1. Leave CALC after exactly N edges, to FIXUP.
- FIXUP, one edge:
  - Negate the quotient if the operand signs differ (signed ops only).
  - Negate the remainder if the dividend was negative (signed ops only).
  - Go to DONE.
- DONE:
  - q_valid=1 and q_res is stable.
  - q_valid && q_ready moves to IDLE on that edge. d_ready rises the following cycle; no back-to-back accept in DONE.
  - Without q_ready, hold DONE indefinitely.
- Latency, measured from the accept cycle to the first q_valid cycle:
  - Normal path: N+2 cycles (34 for bits_per_cycle=1, 10 for 4).
  - Special cases: 1 cycle.
- clear in any state:
  - Go to IDLE next edge, q_valid=0 next cycle, partial results discarded.
  - clear overrides a simultaneous d_valid (no accept) and a simultaneous q_ready.
- rst mid-operation: identical to the reset state; any in-flight result is lost.
- d_lhs, d_rhs and d_funct3 are ignored while not accepting. Operands may change after accept without affecting the result.
- Width rules:
  - All arithmetic is mod 2^32.
  - The remainder satisfies |rem| < |rhs|, and the sign of rem equals the sign of lhs, or rem is 0.

Optional Feature:
Macro name: BOA_DIV_CACHE_EN.
- When defined, the block keeps the last completed operands, the signedness, and both quotient and remainder.
  - Cache entries are written on the FIXUP->DONE transition and on special-case completion.
- An accepted request with equal lhs, rhs and funct3[0] while the cache is valid goes IDLE->DONE with latency 1. This covers DIV followed by REM on the same operands.
- Cache invalidation:
  - rst invalidates the cache.
  - clear does not invalidate a completed entry.
  - An abort mid-CALC never writes the cache.
- When the macro is undefined, no cache registers exist and every non-special request takes N+2 cycles.

Decomposition:
- The shared package boa_pkg carries:
  - funct3 constants: BOA_DIV=3'b100, BOA_DIVU=3'b101, BOA_REM=3'b110, BOA_REMU=3'b111.
  - The state enum type boa_div_state_t.
- One natural sub-module, boa_div_step: a combinational radix-2^bits_per_cycle restoring step. It takes the partial remainder, the dividend bits and the divisor, and returns the next partial remainder and quotient bits. It is instantiated once in CALC.

Test Plan:
1. DIVU 100/7, bits_per_cycle=1: accept, q_valid after 34 cycles, q_res=14. REMU 100/7 in a separate run -> q_res=2.
2. DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
3. DIV 5/0 -> 0xFFFFFFFF with latency 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
4. q_ready held low for 5 cycles in DONE: q_valid and q_res stay stable and d_ready stays 0. Raising q_ready returns the block to IDLE and d_ready goes to 1 the next cycle.
5. clear asserted at CALC iteration 10: q_valid never rises and the block is in IDLE next cycle. A new DIVU 9/3 then yields 3 with full latency. clear together with d_valid in IDLE results in no accept.
6. With BOA_DIV_CACHE_EN: DIV 1000/-3 (-333, full latency), then REM 1000/-3 -> 1 with latency 1. DIVU on the same bits is a cache miss (full latency). After rst, the cache is a miss.

Source files
------------

// File: rtl/boa_pkg.sv
// Shared divider definitions: RV32M divide funct3 codes, sequencer states, operand helper.
package boa_pkg;

  localparam logic [2:0] BOA_DIV  = 3'b100;
  localparam logic [2:0] BOA_DIVU = 3'b101;
  localparam logic [2:0] BOA_REM  = 3'b110;
  localparam logic [2:0] BOA_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } boa_div_state_t;

  // Magnitude of a signed operand; 0x80000000 maps to itself, which is correct as unsigned.
  function automatic logic [31:0] boa_abs(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/boa_div_step.sv
// Combinational restoring divide step resolving BPC quotient bits, MSB first.
module boa_div_step #(
  parameter int BPC = 1
) (
  input  logic [32:0]    rem_in,
  input  logic [BPC-1:0] dvd_bits,
  input  logic [31:0]    dvs,
  output logic [32:0]    rem_out,
  output logic [BPC-1:0] q_bits
);

  always_comb begin
    logic [32:0] r;
    logic [32:0] t;
    r      = rem_in;
    t      = '0;
    q_bits = '0;
    for (int i = BPC - 1; i >= 0; i--) begin
      r = {r[31:0], dvd_bits[i]};
      // Partial remainder stays below 2*dvs, so bit 32 of the difference is a clean borrow.
      t = r - {1'b0, dvs};
      if (!t[32]) begin
        r         = t;
        q_bits[i] = 1'b1;
      end
    end
    rem_out = r;
  end

endmodule

// File: rtl/boa_div_ctl.sv
// Iterative RV32M divider + sequencer: N+2 cycle latency (1 for special cases), result held until q_ready.
// Optional BOA_DIV_CACHE_EN keeps the last completed operands/results for 1-cycle repeat hits.
module boa_div_ctl
  import boa_pkg::*;
#(
  parameter int bits_per_cycle = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_lhs,
  input  logic [31:0] d_rhs,
  output logic        q_valid,
  input  logic        q_ready,
  output logic [31:0] q_res,
  output logic        busy
);

  localparam int          BPC      = bits_per_cycle;
  localparam int          N        = 32 / BPC;
  localparam logic [4:0]  CNT_LAST = 5'(N - 1);

  boa_div_state_t state;
  logic [4:0]     cnt;
  logic           rem_sel;
  logic           neg_q;
  logic           neg_r;
  logic [32:0]    rem_r;
  logic [31:0]    dvd_r;
  logic [31:0]    dvs_r;

  logic           acc;
  logic           sgn_op;
  logic           div0;
  logic           ovf;
  logic [31:0]    spc_q;
  logic [31:0]    spc_r;
  logic [31:0]    fix_q;
  logic [31:0]    fix_r;
  logic [32:0]    step_rem;
  logic [BPC-1:0] step_q;
  logic           hit;
  logic [31:0]    hit_res;

  assign acc    = d_valid && d_ready && !clear;
  assign sgn_op = (d_funct3 == BOA_DIV) || (d_funct3 == BOA_REM);
  assign div0   = (d_rhs == 32'd0);
  assign ovf    = sgn_op && (d_lhs == 32'h8000_0000) && (d_rhs == 32'hFFFF_FFFF);
  assign spc_q  = div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign spc_r  = div0 ? d_lhs : 32'd0;

  // dvd_r has been fully replaced by quotient bits once CALC finishes.
  assign fix_q  = neg_q ? (32'd0 - dvd_r) : dvd_r;
  assign fix_r  = neg_r ? (32'd0 - rem_r[31:0]) : rem_r[31:0];

  boa_div_step #(.BPC(BPC)) u_step (
    .rem_in   (rem_r),
    .dvd_bits (dvd_r[31 -: BPC]),
    .dvs      (dvs_r),
    .rem_out  (step_rem),
    .q_bits   (step_q)
  );

`ifdef BOA_DIV_CACHE_EN
  logic        c_vld;
  logic        c_uns;
  logic [31:0] c_lhs;
  logic [31:0] c_rhs;
  logic [31:0] c_q;
  logic [31:0] c_r;
  logic [31:0] lhs_r;
  logic [31:0] rhs_r;
  logic        uns_r;

  assign hit     = c_vld && (c_lhs == d_lhs) && (c_rhs == d_rhs) && (c_uns == d_funct3[0]);
  assign hit_res = d_funct3[1] ? c_r : c_q;

  // Raw operands are kept through CALC so the entry can be written at FIXUP.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld <= 1'b0;
      c_uns <= 1'b0;
      c_lhs <= '0;
      c_rhs <= '0;
      c_q   <= '0;
      c_r   <= '0;
      lhs_r <= '0;
      rhs_r <= '0;
      uns_r <= 1'b0;
    end else begin
      if (acc) begin
        lhs_r <= d_lhs;
        rhs_r <= d_rhs;
        uns_r <= d_funct3[0];
      end
      if (acc && (div0 || ovf)) begin
        c_vld <= 1'b1;
        c_lhs <= d_lhs;
        c_rhs <= d_rhs;
        c_uns <= d_funct3[0];
        c_q   <= spc_q;
        c_r   <= spc_r;
      end else if (state == ST_FIXUP && !clear) begin
        c_vld <= 1'b1;
        c_lhs <= lhs_r;
        c_rhs <= rhs_r;
        c_uns <= uns_r;
        c_q   <= fix_q;
        c_r   <= fix_r;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = 32'd0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      q_valid <= 1'b0;
      d_ready <= 1'b1;
      busy    <= 1'b0;
      q_res   <= '0;
      cnt     <= '0;
      rem_sel <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      rem_r   <= '0;
      dvd_r   <= '0;
      dvs_r   <= '0;
    end else if (clear) begin
      state   <= ST_IDLE;
      q_valid <= 1'b0;
      d_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            rem_sel <= d_funct3[1];
            busy    <= 1'b1;
            d_ready <= 1'b0;
            if (div0 || ovf) begin
              q_res   <= d_funct3[1] ? spc_r : spc_q;
              q_valid <= 1'b1;
              state   <= ST_DONE;
            end else if (hit) begin
              q_res   <= hit_res;
              q_valid <= 1'b1;
              state   <= ST_DONE;
            end else begin
              neg_q <= sgn_op && (d_lhs[31] ^ d_rhs[31]);
              neg_r <= sgn_op && d_lhs[31];
              dvd_r <= boa_abs(d_lhs, sgn_op);
              dvs_r <= boa_abs(d_rhs, sgn_op);
              rem_r <= '0;
              cnt   <= CNT_LAST;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_r <= step_rem;
          dvd_r <= {dvd_r[31-BPC:0], step_q};
          cnt   <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state <= ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          q_res   <= rem_sel ? fix_r : fix_q;
          q_valid <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          if (q_ready) begin
            q_valid <= 1'b0;
            d_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          q_valid <= 1'b0;
          d_ready <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boa_div_ctl.sv
// Directed and randomized checks of boa_div_ctl against an arithmetic reference model.
module tb_boa_div_ctl;
  import boa_pkg::*;

  localparam int BPC = 1;
  localparam int N   = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_funct3;
  logic [31:0] d_lhs;
  logic [31:0] d_rhs;
  logic        q_valid;
  logic        q_ready;
  logic [31:0] q_res;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference view of the result cache: last completed (lhs, rhs, unsigned).
  bit          mc_vld = 1'b0;
  logic [31:0] mc_lhs;
  logic [31:0] mc_rhs;
  logic        mc_uns;

  always #5 clk = ~clk;

  boa_div_ctl #(.bits_per_cycle(BPC)) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .d_funct3 (d_funct3),
    .d_lhs    (d_lhs),
    .d_rhs    (d_rhs),
    .q_valid  (q_valid),
    .q_ready  (q_ready),
    .q_res    (q_res),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (f[0]) begin
      q = a / b;
      r = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return f[1] ? r : q;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef BOA_DIV_CACHE_EN
    if (mc_vld && mc_lhs == a && mc_rhs == b && mc_uns == f[0]) return 1;
`endif
    return N + 2;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          lat;
    int          el;
    logic [31:0] er;
    er = ref_res(f, a, b);
    el = exp_lat(f, a, b);
    @(negedge clk);
    check({tag, "/rdy"}, 32'(d_ready), 32'd1);
    d_valid  = 1'b1;
    d_funct3 = f;
    d_lhs    = a;
    d_rhs    = b;
    @(negedge clk);
    // Scramble operands after accept; the result must not depend on them.
    d_valid  = 1'b0;
    d_lhs    = $urandom;
    d_rhs    = $urandom;
    d_funct3 = 3'($urandom);
    lat = 1;
    while (q_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/lat"}, 32'(lat), 32'(el));
    check({tag, "/res"}, q_res, er);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_vld"}, 32'(q_valid), 32'd1);
      check({tag, "/hold_res"}, q_res, er);
      check({tag, "/hold_rdy"}, 32'(d_ready), 32'd0);
    end
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
    check({tag, "/drain_vld"}, 32'(q_valid), 32'd0);
    check({tag, "/drain_rdy"}, 32'(d_ready), 32'd1);
    mc_vld = 1'b1;
    mc_lhs = a;
    mc_rhs = b;
    mc_uns = f[0];
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          kind;
    int          qv_seen;
    logic [1:0]  sel;

    rst      = 1'b1;
    clear    = 1'b0;
    d_valid  = 1'b0;
    q_ready  = 1'b0;
    d_funct3 = 3'd0;
    d_lhs    = 32'd0;
    d_rhs    = 32'd0;
    repeat (2) @(negedge clk);
    check("reset/q_valid", 32'(q_valid), 32'd0);
    check("reset/d_ready", 32'(d_ready), 32'd1);
    check("reset/busy", 32'(busy), 32'd0);
    check("reset/q_res", q_res, 32'd0);
    rst = 1'b0;

    run_op("divu100_7", BOA_DIVU, 32'd100, 32'd7, 0);
    run_op("remu100_7", BOA_REMU, 32'd100, 32'd7, 0);
    run_op("div-7_2", BOA_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem-7_2", BOA_REM, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("div7_-2", BOA_DIV, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("rem7_-2", BOA_REM, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("div5_0", BOA_DIV, 32'd5, 32'd0, 0);
    run_op("remu5_0", BOA_REMU, 32'd5, 32'd0, 0);
    run_op("div_ovf", BOA_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", BOA_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("hold", BOA_DIVU, 32'd12345, 32'd11, 5);

    // Abort at CALC iteration 10.
    @(negedge clk);
    d_valid  = 1'b1;
    d_funct3 = BOA_DIVU;
    d_lhs    = 32'd1000;
    d_rhs    = 32'd7;
    @(negedge clk);
    d_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort/busy_before", 32'(busy), 32'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort/busy", 32'(busy), 32'd0);
    check("abort/d_ready", 32'(d_ready), 32'd1);
    qv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (q_valid !== 1'b0) qv_seen++;
    end
    check("abort/q_valid_never", 32'(qv_seen), 32'd0);
    run_op("divu9_3", BOA_DIVU, 32'd9, 32'd3, 0);

    // clear wins over a simultaneous request in IDLE.
    @(negedge clk);
    clear    = 1'b1;
    d_valid  = 1'b1;
    d_funct3 = BOA_DIVU;
    d_lhs    = 32'd5;
    d_rhs    = 32'd0;
    @(negedge clk);
    clear   = 1'b0;
    d_valid = 1'b0;
    check("clr_req/busy", 32'(busy), 32'd0);
    check("clr_req/q_valid", 32'(q_valid), 32'd0);

    // Cache sequence (hits only when the cache is compiled in; the model decides latency).
    run_op("div1000_-3", BOA_DIV, 32'd1000, 32'hFFFF_FFFD, 0);
    run_op("rem1000_-3", BOA_REM, 32'd1000, 32'hFFFF_FFFD, 0);
    run_op("divu1000_-3", BOA_DIVU, 32'd1000, 32'hFFFF_FFFD, 0);

    // Reset in the middle of CALC.
    @(negedge clk);
    d_valid  = 1'b1;
    d_funct3 = BOA_DIV;
    d_lhs    = 32'd77;
    d_rhs    = 32'd5;
    @(negedge clk);
    d_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    mc_vld = 1'b0;
    check("rst_mid/q_valid", 32'(q_valid), 32'd0);
    check("rst_mid/d_ready", 32'(d_ready), 32'd1);
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/q_res", q_res, 32'd0);
    run_op("divu1000_-3_postrst", BOA_DIVU, 32'd1000, 32'hFFFF_FFFD, 0);

    for (int k = 0; k < 30; k++) begin
      sel  = 2'($urandom_range(0, 3));
      f    = {1'b1, sel};
      kind = $urandom_range(0, 7);
      a    = $urandom;
      b    = $urandom;
      case (kind)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 15); end
        3: begin a = -32'($urandom_range(1, 200)); b = $urandom_range(1, 15); end
        4: if (mc_vld) begin a = mc_lhs; b = mc_rhs; end
        5: b = 32'($urandom_range(1, 3)) << 30;
        default: ;
      endcase
      run_op("rand", f, a, b, k % 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
